// File: rtl/pmp_iter_check.sv
// rtl/pmp_iter_check.sv - iterative PMP permission check scanning a fixed number of entries per cycle
package config_pkg;
    typedef struct packed {
        int unsigned nr_pmp_entries;
    } cva6_cfg_t;

    // A zero entry count means "use every entry the checker is built with"
    localparam cva6_cfg_t cva6_cfg_empty = '{nr_pmp_entries: 32'd0};
endpackage

package riscv;
    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    // bit 0 = read, bit 1 = write, bit 2 = execute
    typedef logic [2:0] pmp_access_t;

    typedef struct packed {
        logic x;
        logic w;
        logic r;
    } pmpcfg_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access_type;
    } pmpcfg_t;
endpackage

module pmp_iter_check #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int unsigned PLEN              = 56,
    parameter int unsigned PMP_LEN           = 54,
    parameter int unsigned NR_ENTRIES        = 16,
    parameter int unsigned ENTRIES_PER_CYCLE = 4,
    localparam int unsigned IDX_W            = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [PLEN-1:0]                       req_addr_i,
    input  riscv::pmp_access_t                    req_access_i,
    input  riscv::priv_lvl_t                      req_priv_i,
    input  logic [NR_ENTRIES-1:0][PMP_LEN-1:0]    conf_addr_i,
    input  riscv::pmpcfg_t [NR_ENTRIES-1:0]       conf_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic                                  rsp_allow_o,
    output logic                                  rsp_matched_o,
    output logic [IDX_W-1:0]                      rsp_idx_o
);

    localparam int unsigned NR_GROUPS = NR_ENTRIES / ENTRIES_PER_CYCLE;
    localparam int unsigned G_W       = (NR_GROUPS > 1) ? $clog2(NR_GROUPS) : 1;
    // One spare bit above pmpaddr<<2 so an all-ones NAPOT mask never wraps
    localparam int unsigned CMP_W     = (PLEN > PMP_LEN + 3) ? PLEN : PMP_LEN + 3;
    localparam int unsigned NR_ACTIVE =
        (CVA6Cfg.nr_pmp_entries == 0 || CVA6Cfg.nr_pmp_entries > NR_ENTRIES)
            ? NR_ENTRIES : CVA6Cfg.nr_pmp_entries;
    localparam logic [G_W-1:0] LAST_G = G_W'(NR_GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [PLEN-1:0]    addr_q;
    riscv::pmp_access_t access_q;
    riscv::priv_lvl_t   priv_q;
    logic [G_W-1:0]     g_q;

    // Decision of the group scanned last cycle; it is handed to the response
    // registers one cycle later, which gives the fixed k+2 latency.
    logic               dec_valid_q;
    logic               dec_allow_q;
    logic               dec_matched_q;
    logic [IDX_W-1:0]   dec_idx_q;

    logic               rsp_allow_q;
    logic               rsp_matched_q;
    logic [IDX_W-1:0]   rsp_idx_q;

    logic [NR_ENTRIES-1:0] entry_match;
    logic                  grp_hit;
    logic                  grp_allow;
    logic [IDX_W-1:0]      grp_idx;
    logic [CMP_W-1:0]      addr_ext;

    assign addr_ext = CMP_W'(addr_q);

    for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_entry
        localparam logic ACTIVE = (i < NR_ACTIVE);

        logic [CMP_W-1:0]   top;
        logic [CMP_W-1:0]   bot;
        logic [CMP_W-1:0]   napot_mask;
        logic [PMP_LEN:0]   napot_ones;
        logic               hit;
        logic               unused_rsvd;

        assign top = CMP_W'({conf_addr_i[i], 2'b00});

        if (i == 0) begin : g_first
            assign bot = '0;
        end else begin : g_rest
            assign bot = CMP_W'({conf_addr_i[i-1], 2'b00});
        end

        // x ^ (x+1) keeps the trailing ones plus the next bit: t+1 ones,
        // which with the two byte-offset bits gives the t+3 bit region size.
        assign napot_ones = {1'b0, conf_addr_i[i]} ^ ({1'b0, conf_addr_i[i]} + (PMP_LEN+1)'(1));
        assign napot_mask = CMP_W'({napot_ones, 2'b11});
        assign unused_rsvd = ^conf_i[i].reserved;

        // Address match of this entry against the registered request
        always_comb begin
            hit = 1'b0;
            unique case (conf_i[i].addr_mode)
                riscv::TOR:   hit = (addr_ext >= bot) && (addr_ext < top);
                riscv::NA4:   hit = (addr_ext[CMP_W-1:2] == top[CMP_W-1:2]);
                riscv::NAPOT: hit = ((addr_ext & ~napot_mask) == (top & ~napot_mask));
                default:      hit = 1'b0;
            endcase
        end

        assign entry_match[i] = hit & ACTIVE;
    end

    // Lowest matching entry of the current group and its permission verdict
    always_comb begin
        logic [2:0] perm;
        grp_hit   = 1'b0;
        grp_idx   = '0;
        grp_allow = (priv_q == riscv::PRIV_LVL_M);
        perm      = '0;
        for (int i = 0; i < int'(NR_ENTRIES); i++) begin
            if (!grp_hit && entry_match[i] &&
                (G_W'(i / int'(ENTRIES_PER_CYCLE)) == g_q)) begin
                grp_hit   = 1'b1;
                grp_idx   = IDX_W'(i);
                perm      = conf_i[i].access_type;
                grp_allow = ((priv_q == riscv::PRIV_LVL_M) && !conf_i[i].locked) ||
                            ((access_q & ~perm) == 3'b000);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid_i) state_d = SCAN;
            SCAN:    if (dec_valid_q) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
    end

    assign rsp_allow_o   = rsp_allow_q;
    assign rsp_matched_o = rsp_matched_q;
    assign rsp_idx_o     = rsp_idx_q;

    // Request capture, group counter, decision and response registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q        <= '0;
            access_q      <= '0;
            priv_q        <= riscv::PRIV_LVL_U;
            g_q           <= '0;
            dec_valid_q   <= 1'b0;
            dec_allow_q   <= 1'b0;
            dec_matched_q <= 1'b0;
            dec_idx_q     <= '0;
            rsp_allow_q   <= 1'b0;
            rsp_matched_q <= 1'b0;
            rsp_idx_q     <= '0;
        end else if (flush_i) begin
            g_q         <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q      <= req_addr_i;
                        access_q    <= req_access_i;
                        priv_q      <= req_priv_i;
                        g_q         <= '0;
                        dec_valid_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (dec_valid_q) begin
                        rsp_allow_q   <= dec_allow_q;
                        rsp_matched_q <= dec_matched_q;
                        rsp_idx_q     <= dec_idx_q;
                        dec_valid_q   <= 1'b0;
                    end else if (grp_hit || (g_q == LAST_G)) begin
                        dec_valid_q   <= 1'b1;
                        dec_allow_q   <= grp_allow;
                        dec_matched_q <= grp_hit;
                        dec_idx_q     <= grp_idx;
                    end else begin
                        g_q <= g_q + G_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmp_iter_check.sv
// tb/tb_pmp_iter_check.sv - self-checking bench for pmp_iter_check
module tb_pmp_iter_check;

    localparam int PLEN    = 56;
    localparam int PMP_LEN = 54;
    localparam int NR      = 16;
    localparam int EPC     = 4;
    localparam int NG      = NR / EPC;
    localparam int MAX_LAT = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [PLEN-1:0] req_addr = '0;
    logic [2:0] req_access = '0;
    riscv::priv_lvl_t req_priv = riscv::PRIV_LVL_U;
    logic [NR-1:0][PMP_LEN-1:0] conf_addr = '0;
    riscv::pmpcfg_t [NR-1:0] conf = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic rsp_allow;
    logic rsp_matched;
    logic [3:0] rsp_idx;

    int total = 0;
    int bad = 0;

    pmp_iter_check #(
        .PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR), .ENTRIES_PER_CYCLE(EPC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_access_i(req_access), .req_priv_i(req_priv),
        .conf_addr_i(conf_addr), .conf_i(conf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_allow_o(rsp_allow), .rsp_matched_o(rsp_matched), .rsp_idx_o(rsp_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int ia; logic [7:0] ca; logic [PMP_LEN-1:0] aa;
        int ib; logic [7:0] cb; logic [PMP_LEN-1:0] ab;
        logic [PLEN-1:0] addr; logic [2:0] acc; logic [1:0] priv;
        bit m; int idx; bit al; int lat;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mkv(string n, int ia, logic [7:0] ca, logic [PMP_LEN-1:0] aa,
                                 int ib, logic [7:0] cb, logic [PMP_LEN-1:0] ab,
                                 logic [PLEN-1:0] addr, logic [2:0] acc, logic [1:0] priv,
                                 bit m, int idx, bit al, int lat);
        vec_t v;
        v.name = n; v.ia = ia; v.ca = ca; v.aa = aa; v.ib = ib; v.cb = cb; v.ab = ab;
        v.addr = addr; v.acc = acc; v.priv = priv; v.m = m; v.idx = idx; v.al = al; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Behavioural reference: walk the entries as address intervals, lowest index wins
    task automatic ref_model(input logic [PLEN-1:0] a, input logic [2:0] acc, input logic [1:0] priv,
                             output bit m, output int idx, output bit al, output int lat);
        longint unsigned addr, hi, lo, base, size_b;
        bit hit;
        int t;
        logic [2:0] perm;
        addr = 64'(a);
        m = 0; idx = 0; lat = NG + 1; al = (priv == 2'b11);
        for (int i = 0; i < NR; i++) begin
            hi = 64'(conf_addr[i]) * 4;
            lo = 0;
            if (i > 0) lo = 64'(conf_addr[i-1]) * 4;
            hit = 0;
            case (conf[i].addr_mode)
                riscv::TOR: hit = (addr >= lo) && (addr < hi);
                riscv::NA4: hit = (addr >= hi) && (addr < hi + 4);
                riscv::NAPOT: begin
                    t = 0;
                    for (int b = 0; b < PMP_LEN; b++) begin
                        if (conf_addr[i][b]) t++;
                        else break;
                    end
                    size_b = 64'd1 << (t + 3);
                    base = hi - (hi % size_b);
                    hit = (addr >= base) && (addr - base < size_b);
                end
                default: hit = 0;
            endcase
            if (hit) begin
                m = 1; idx = i; lat = i / EPC + 2;
                perm = conf[i].access_type;
                if (priv == 2'b11 && !conf[i].locked) al = 1;
                else begin
                    al = 1;
                    for (int b = 0; b < 3; b++)
                        if (acc[b] && !perm[b]) al = 0;
                end
                break;
            end
        end
    endtask

    task automatic accept(input string name, input logic [PLEN-1:0] a, input logic [2:0] acc,
                          input logic [1:0] priv);
        chk({name, ".ready"}, req_ready, 1);
        req_addr = a; req_access = acc; req_priv = riscv::priv_lvl_t'(priv); req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        // Inputs after acceptance must not influence the result
        req_addr = PLEN'($urandom); req_access = 3'($urandom); req_priv = riscv::PRIV_LVL_M;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!rsp_valid && lat < MAX_LAT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic recover();
        flush = 1; @(posedge clk); #1; flush = 0;
    endtask

    task automatic run_req(input string name, input logic [PLEN-1:0] a, input logic [2:0] acc,
                           input logic [1:0] priv, input bit em, input int eidx, input bit eal,
                           input int elat);
        int lat;
        accept(name, a, acc, priv);
        wait_valid(lat);
        chk({name, ".lat"}, lat, elat);
        if (!rsp_valid) begin
            recover();
        end else begin
            chk({name, ".matched"}, rsp_matched, em);
            chk({name, ".idx"}, rsp_idx, eidx);
            chk({name, ".allow"}, rsp_allow, eal);
            rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
        end
    endtask

    task automatic setup_vec(input vec_t v);
        conf = '0; conf_addr = '0;
        if (v.ia >= 0) begin conf[v.ia] = riscv::pmpcfg_t'(v.ca); conf_addr[v.ia] = v.aa; end
        if (v.ib >= 0) begin conf[v.ib] = riscv::pmpcfg_t'(v.cb); conf_addr[v.ib] = v.ab; end
    endtask

    initial begin
        bit m, al;
        int idx, lat;
        logic [7:0] c;
        logic [PLEN-1:0] a;
        logic [2:0] acc;
        logic [1:0] pv;
        logic [PMP_LEN-1:0] ones;
        ones = '1;

        vt[0]  = mkv("napot_rd",   2, 8'h19, 54'h3FF, -1, 8'h00, 0, 56'h1000, 3'b001, 2'b00, 1, 2, 1, 2);
        vt[1]  = mkv("napot_wr",   2, 8'h19, 54'h3FF, -1, 8'h00, 0, 56'h1000, 3'b010, 2'b00, 1, 2, 0, 2);
        vt[2]  = mkv("prio",       1, 8'h08, 54'h2400, 6, 8'h09, 54'h2400, 56'h8000, 3'b001, 2'b00, 1, 1, 0, 2);
        vt[3]  = mkv("late_grp",   6, 8'h09, 54'h2400, -1, 8'h00, 0, 56'h8000, 3'b001, 2'b00, 1, 6, 1, 3);
        vt[4]  = mkv("none_m",    -1, 8'h00, 0, -1, 8'h00, 0, 56'h1234, 3'b001, 2'b11, 0, 0, 1, NG + 1);
        vt[5]  = mkv("none_s",    -1, 8'h00, 0, -1, 8'h00, 0, 56'h1234, 3'b001, 2'b01, 0, 0, 0, NG + 1);
        vt[6]  = mkv("lock0",      0, 8'h11, 54'h40, -1, 8'h00, 0, 56'h100, 3'b100, 2'b11, 1, 0, 1, 2);
        vt[7]  = mkv("lock1",      0, 8'h91, 54'h40, -1, 8'h00, 0, 56'h100, 3'b100, 2'b11, 1, 0, 0, 2);
        vt[8]  = mkv("na4_out",    0, 8'h11, 54'h40, -1, 8'h00, 0, 56'h104, 3'b001, 2'b00, 0, 0, 0, NG + 1);
        vt[9]  = mkv("na4_last",   0, 8'h11, 54'h40, -1, 8'h00, 0, 56'h103, 3'b001, 2'b00, 1, 0, 1, 2);
        vt[10] = mkv("tor_top",    0, 8'h09, 54'h40, -1, 8'h00, 0, 56'h100, 3'b001, 2'b00, 0, 0, 0, NG + 1);
        vt[11] = mkv("tor_in",     0, 8'h09, 54'h40, -1, 8'h00, 0, 56'hFC, 3'b001, 2'b00, 1, 0, 1, 2);
        vt[12] = mkv("tor_inv",    2, 8'h00, 54'h100, 3, 8'h0F, 54'h80, 56'h200, 3'b001, 2'b00, 0, 0, 0, NG + 1);
        vt[13] = mkv("acc_none",   5, 8'h10, 54'h10, -1, 8'h00, 0, 56'h40, 3'b000, 2'b00, 1, 5, 1, 3);
        vt[14] = mkv("all_ones_w", 15, 8'h19, ones, -1, 8'h00, 0, {PLEN{1'b1}}, 3'b010, 2'b00, 1, 15, 0, NG + 1);
        vt[15] = mkv("all_ones_r", 15, 8'h19, ones, -1, 8'h00, 0, {PLEN{1'b1}}, 3'b001, 2'b00, 1, 15, 1, NG + 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.valid", rsp_valid, 0);
        chk("rst.allow", rsp_allow, 0);
        chk("rst.matched", rsp_matched, 0);
        chk("rst.idx", rsp_idx, 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("rst.ready", req_ready, 1);

        // Directed vector table
        for (int k = 0; k < 16; k++) begin
            setup_vec(vt[k]);
            run_req(vt[k].name, vt[k].addr, vt[k].acc, vt[k].priv,
                    vt[k].m, vt[k].idx, vt[k].al, vt[k].lat);
        end

        // Backpressure: response held while rsp_ready is low, no new request accepted
        setup_vec(vt[2]);
        accept("bp", 56'h8000, 3'b001, 2'b00);
        wait_valid(lat);
        chk("bp.lat", lat, 2);
        req_valid = 1; req_addr = 56'h0;
        for (int k = 0; k < 5; k++) begin
            chk("bp.valid", rsp_valid, 1);
            chk("bp.ready", req_ready, 0);
            chk("bp.idx", rsp_idx, 1);
            chk("bp.allow", rsp_allow, 0);
            chk("bp.matched", rsp_matched, 1);
            @(posedge clk); #1;
        end
        req_valid = 0;
        rsp_ready = 1; @(posedge clk); #1; rsp_ready = 0;
        chk("bp.idle", req_ready, 1);

        // Flush in RESP drops the response
        setup_vec(vt[0]);
        accept("flr", 56'h1000, 3'b001, 2'b00);
        wait_valid(lat);
        chk("flr.valid", rsp_valid, 1);
        flush = 1; @(posedge clk); #1; flush = 0;
        chk("flr.dropped", rsp_valid, 0);
        chk("flr.ready", req_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("flr.quiet", rsp_valid, 0);

        // Flush mid-scan: nothing comes back, the next request works normally
        setup_vec(vt[4]);
        accept("fls", 56'h1234, 3'b001, 2'b11);
        @(posedge clk); #1;
        flush = 1; @(posedge clk); #1; flush = 0;
        repeat (8) begin
            @(posedge clk); #1;
            chk("fls.quiet", rsp_valid, 0);
        end
        run_req("fls.next", 56'h1234, 3'b001, 2'b11, 0, 0, 1, NG + 1);

        // Reset mid-scan returns outputs to reset values (previous response had idx 2)
        setup_vec(vt[0]);
        run_req("pre_rst", 56'h1000, 3'b001, 2'b00, 1, 2, 1, 2);
        conf = '0;
        accept("rsc", 56'h1000, 3'b001, 2'b00);
        @(posedge clk); #1;
        rst_n = 0; flush = 1; @(posedge clk); #1; rst_n = 1; flush = 0;
        chk("rsc.valid", rsp_valid, 0);
        chk("rsc.allow", rsp_allow, 0);
        chk("rsc.matched", rsp_matched, 0);
        chk("rsc.idx", rsp_idx, 0);
        chk("rsc.ready", req_ready, 1);
        repeat (7) @(posedge clk);
        #1;
        chk("rsc.quiet", rsp_valid, 0);

        // Randomized configurations against the reference model
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NR; i++) begin
                c = 8'($urandom);
                c[6:5] = 2'b00;
                if ($urandom_range(0, 2) == 0) c[4:3] = 2'b00;
                conf[i] = riscv::pmpcfg_t'(c);
                conf_addr[i] = PMP_LEN'($urandom_range(0, 511));
            end
            a = PLEN'($urandom_range(0, 2047));
            acc = 3'($urandom);
            case ($urandom_range(0, 2))
                0: pv = 2'b00;
                1: pv = 2'b01;
                default: pv = 2'b11;
            endcase
            ref_model(a, acc, pv, m, idx, al, lat);
            run_req($sformatf("rnd%0d", it), a, acc, pv, m, idx, al, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
